xchg_reg_file: RTL and testbench
================================

Name: xchg_reg_file

Overview:
Parametrised register file with one external write port, one external read port and an internal command engine. The engine executes SWAP, COPY and CLEAR between two addressed entries under a ready/request/done handshake. It supersedes the single-purpose swap register file and sits alongside CPU/datapath blocks that need atomic multi-entry moves without external sequencing.

Parameters:
addr_width, 7, address width; depth = 2**addr_width entries
data_width, 8, bits per entry

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
we  in  1  external write enable
address_w  in  addr_width  external write address
data_w  in  data_width  external write data
address_r  in  addr_width  external read address
data_r  out  data_width  external read data (combinational from address_r)
op_req  in  1  command request
op_code  in  2  00=NOP, 01=SWAP, 10=COPY (A->B), 11=CLEAR (A<=0)
address_A  in  addr_width  operand A
address_B  in  addr_width  operand B
op_ready  out  1  engine idle, command can be accepted
op_done  out  1  one-cycle pulse, command complete
wr_drop  out  1  one-cycle pulse, external write discarded because engine busy

Behaviour:
- Reset: async assert; state=IDLE, tmp=0, op_ready=1, op_done=0, wr_drop=0. Storage array contents are NOT reset (undefined until written). data_r follows the array combinationally.
- Accept: on an edge where op_req=1 and op_ready=1 and op_code!=NOP, the engine latches op_code, address_A and address_B. After acceptance, inputs are don't-care until op_done. op_req with NOP is ignored. op_req while op_ready=0 is ignored; there is no queueing.
- FSM states: IDLE, RD_A, WR_A, WR_B, CPY, CLR, DONE. Only IDLE drives op_ready=1. DONE drives op_done=1 for exactly one cycle, then returns to IDLE.
- SWAP: IDLE->RD_A (tmp<=mem[A]) ->WR_A (mem[A]<=mem[B]) ->WR_B (mem[B]<=tmp) ->DONE->IDLE. op_done is high in the 4th cycle after the accept edge.
- COPY: IDLE->CPY (mem[B]<=mem[A]) ->DONE. op_done is high in the 2nd cycle after accept.
- CLEAR: IDLE->CLR (mem[A]<=0) ->DONE. Same latency as COPY.
- A==B: SWAP and COPY run the full sequence and leave contents unchanged; op_done still pulses.
- External writes are honoured only in IDLE. A we=1 in any other state does not write and pulses wr_drop in the next cycle.
- Simultaneous we and accept in IDLE: the external write commits on the accept edge, and the command sees the post-write contents.
- External read is always live. During an operation, data_r reflects intermediate array contents; no stalling.
- Reset asserted mid-operation aborts immediately. Entries already written keep their new value; remaining steps are lost; op_done is not pulsed.
- Internal array: two read ports (external, engine) and one write port. The write mux priority is engine over external; an external write while the engine is active is dropped, not merged.

Decomposition:
- Package xchg_reg_file_pkg: op_code constants (OP_NOP, OP_SWAP, OP_COPY, OP_CLEAR), FSM state encoding.
- Sub-module reg_file_2r1w (addr_width, data_width): async-read dual-port, sync-write storage. The top level holds the FSM, tmp register and write-address/data muxing.

Test Plan:
- Write mem[3]=0x11, mem[9]=0x22 in IDLE; SWAP A=3 B=9 -> op_ready low for 4 cycles, op_done in 4th cycle; then mem[3]=0x22, mem[9]=0x11 via data_r.
- COPY A=5 (0xA5) B=6 (0x00) -> op_done 2nd cycle; mem[6]=0xA5, mem[5]=0xA5. CLEAR A=5 -> mem[5]=0x00.
- SWAP A=B=7 (0x3C) -> op_done after 4 cycles, mem[7]=0x3C.
- During SWAP, drive we=1 address_w=3 data_w=0xFF in WR_A -> wr_drop pulses next cycle; mem[3] ends at the swapped value, not 0xFF. op_req asserted in the same window is ignored (no second op_done).
- Same edge: we to mem[2]=0x44 and SWAP A=2 B=4 (mem[4]=0x55) -> mem[2]=0x55, mem[4]=0x44.
- Deassert reset_n during WR_B of SWAP 3<->9 -> op_ready=1 and op_done=0 immediately; mem[3] holds the new value and mem[9] is unchanged.

Source files
------------

// File: rtl/xchg_reg_file_pkg.sv
// Shared command encodings and engine state type for the exchange register file.
package xchg_reg_file_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SWAP  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StWrA,
    StWrB,
    StCpy,
    StClr,
    StDone
  } state_e;

endpackage

// File: rtl/reg_file_2r1w.sv
// Storage array: two asynchronous read ports, one synchronous write port, no reset.
module reg_file_2r1w #(
  parameter int unsigned addr_width = 7,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr_a,
  output logic [data_width-1:0] rdata_a,
  input  logic [addr_width-1:0] raddr_b,
  output logic [data_width-1:0] rdata_b
);

  localparam int unsigned depth = 2 ** addr_width;

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/xchg_reg_file.sv
// Register file with an internal engine performing SWAP, COPY and CLEAR between two entries.
module xchg_reg_file
  import xchg_reg_file_pkg::*;
#(
  parameter int unsigned addr_width = 7,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [addr_width-1:0] address_w,
  input  logic [data_width-1:0] data_w,
  input  logic [addr_width-1:0] address_r,
  output logic [data_width-1:0] data_r,
  input  logic                  op_req,
  input  logic [1:0]            op_code,
  input  logic [addr_width-1:0] address_A,
  input  logic [addr_width-1:0] address_B,
  output logic                  op_ready,
  output logic                  op_done,
  output logic                  wr_drop
);

  state_e                state_q, state_d;
  logic [data_width-1:0] tmp_q, tmp_d;
  logic [addr_width-1:0] a_q, b_q;
  logic                  wr_drop_q;

  logic                  mem_we;
  logic [addr_width-1:0] mem_waddr;
  logic [data_width-1:0] mem_wdata;
  logic [addr_width-1:0] eng_raddr;
  logic [data_width-1:0] eng_rdata;
  logic                  accept;

  assign accept = op_req && (state_q == StIdle) && (op_code != OP_NOP);

  reg_file_2r1w #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .raddr_a(address_r),
    .rdata_a(data_r),
    .raddr_b(eng_raddr),
    .rdata_b(eng_rdata)
  );

  // Engine writes own the port outside IDLE; external writes only reach it in IDLE.
  always_comb begin
    state_d   = state_q;
    tmp_d     = tmp_q;
    mem_we    = 1'b0;
    mem_waddr = address_w;
    mem_wdata = data_w;
    eng_raddr = a_q;
    op_ready  = 1'b0;
    op_done   = 1'b0;
    case (state_q)
      StIdle: begin
        op_ready = 1'b1;
        mem_we   = we;
        if (accept) begin
          case (op_code)
            OP_SWAP:  state_d = StRdA;
            OP_COPY:  state_d = StCpy;
            OP_CLEAR: state_d = StClr;
            default:  state_d = StIdle;
          endcase
        end
      end
      StRdA: begin
        tmp_d   = eng_rdata;
        state_d = StWrA;
      end
      StWrA: begin
        eng_raddr = b_q;
        mem_we    = 1'b1;
        mem_waddr = a_q;
        mem_wdata = eng_rdata;
        state_d   = StWrB;
      end
      StWrB: begin
        mem_we    = 1'b1;
        mem_waddr = b_q;
        mem_wdata = tmp_q;
        state_d   = StDone;
      end
      StCpy: begin
        mem_we    = 1'b1;
        mem_waddr = b_q;
        mem_wdata = eng_rdata;
        state_d   = StDone;
      end
      StClr: begin
        mem_we    = 1'b1;
        mem_waddr = a_q;
        mem_wdata = '0;
        state_d   = StDone;
      end
      StDone: begin
        op_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tmp_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmp_q     <= tmp_d;
      wr_drop_q <= we && (state_q != StIdle);
      if (accept) begin
        a_q <= address_A;
        b_q <= address_B;
      end
    end
  end

  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_xchg_reg_file.sv
// Directed self-checking bench for xchg_reg_file.
module tb_xchg_reg_file;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       we = 1'b0;
  logic [6:0] address_w = '0;
  logic [7:0] data_w = '0;
  logic [6:0] address_r = '0;
  logic [7:0] data_r;
  logic       op_req = 1'b0;
  logic [1:0] op_code = 2'b00;
  logic [6:0] address_A = '0;
  logic [6:0] address_B = '0;
  logic       op_ready;
  logic       op_done;
  logic       wr_drop;

  int tests_run = 0;
  int tests_failed = 0;

  xchg_reg_file #(
    .addr_width(7),
    .data_width(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (we),
    .address_w(address_w),
    .data_w   (data_w),
    .address_r(address_r),
    .data_r   (data_r),
    .op_req   (op_req),
    .op_code  (op_code),
    .address_A(address_A),
    .address_B(address_B),
    .op_ready (op_ready),
    .op_done  (op_done),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [6:0] a, input logic [7:0] d);
    we = 1'b1; address_w = a; data_w = d;
    step();
    we = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] code, input logic [6:0] a, input logic [6:0] b);
    op_req = 1'b1; op_code = code; address_A = a; address_B = b;
    step();
    op_req = 1'b0; op_code = 2'b00;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (op_ready !== 1'b1 || op_done !== 1'b0 || wr_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b done=%b drop=%b required 1 0 0",
               op_ready, op_done, wr_drop);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_swap();
    write_mem(7'd3, 8'h11);
    write_mem(7'd9, 8'h22);
    address_r = 7'd3; #1;
    tests_run++;
    if (data_r !== 8'h11) begin
      tests_failed++; $display("FAIL ext_write: got %h required 11", data_r);
    end
    start_op(2'b01, 7'd3, 7'd9);
    for (int k = 1; k <= 4; k++) begin
      tests_run++;
      if (op_ready !== 1'b0 || op_done !== (k == 4)) begin
        tests_failed++;
        $display("FAIL swap_cycle%0d: ready=%b done=%b required 0 %b", k, op_ready, op_done,
                 (k == 4));
      end
      step();
    end
    tests_run++;
    if (op_ready !== 1'b1 || op_done !== 1'b0) begin
      tests_failed++; $display("FAIL swap_idle: ready=%b done=%b required 1 0", op_ready, op_done);
    end
    address_r = 7'd3; #1;
    tests_run++;
    if (data_r !== 8'h22) begin
      tests_failed++; $display("FAIL swap_mem3: got %h required 22", data_r);
    end
    address_r = 7'd9; #1;
    tests_run++;
    if (data_r !== 8'h11) begin
      tests_failed++; $display("FAIL swap_mem9: got %h required 11", data_r);
    end
  endtask

  task automatic test_copy_clear();
    write_mem(7'd5, 8'hA5);
    write_mem(7'd6, 8'h00);
    start_op(2'b10, 7'd5, 7'd6);
    tests_run++;
    if (op_ready !== 1'b0 || op_done !== 1'b0) begin
      tests_failed++; $display("FAIL copy_cycle1: ready=%b done=%b required 0 0", op_ready, op_done);
    end
    step();
    tests_run++;
    if (op_done !== 1'b1) begin
      tests_failed++; $display("FAIL copy_done: got %b required 1", op_done);
    end
    step();
    address_r = 7'd6; #1;
    tests_run++;
    if (data_r !== 8'hA5) begin
      tests_failed++; $display("FAIL copy_mem6: got %h required a5", data_r);
    end
    address_r = 7'd5; #1;
    tests_run++;
    if (data_r !== 8'hA5) begin
      tests_failed++; $display("FAIL copy_mem5: got %h required a5", data_r);
    end
    start_op(2'b11, 7'd5, 7'd0);
    step();
    tests_run++;
    if (op_done !== 1'b1) begin
      tests_failed++; $display("FAIL clear_done: got %b required 1", op_done);
    end
    step();
    address_r = 7'd5; #1;
    tests_run++;
    if (data_r !== 8'h00) begin
      tests_failed++; $display("FAIL clear_mem5: got %h required 00", data_r);
    end
  endtask

  task automatic test_swap_same();
    write_mem(7'd7, 8'h3C);
    start_op(2'b01, 7'd7, 7'd7);
    for (int k = 1; k <= 4; k++) begin
      tests_run++;
      if (op_done !== (k == 4)) begin
        tests_failed++; $display("FAIL same_cycle%0d: done=%b required %b", k, op_done, (k == 4));
      end
      step();
    end
    address_r = 7'd7; #1;
    tests_run++;
    if (data_r !== 8'h3C) begin
      tests_failed++; $display("FAIL same_mem7: got %h required 3c", data_r);
    end
  endtask

  task automatic test_drop();
    int extra_done = 0;
    write_mem(7'd3, 8'h11);
    write_mem(7'd9, 8'h22);
    start_op(2'b01, 7'd3, 7'd9);
    step();
    // Now in WR_A: external write and a new request must both be ignored
    we = 1'b1; address_w = 7'd3; data_w = 8'hFF;
    op_req = 1'b1; op_code = 2'b10; address_A = 7'd9; address_B = 7'd3;
    step();
    we = 1'b0; op_req = 1'b0; op_code = 2'b00;
    tests_run++;
    if (wr_drop !== 1'b1) begin
      tests_failed++; $display("FAIL drop_pulse: got %b required 1", wr_drop);
    end
    step();
    tests_run++;
    if (op_done !== 1'b1 || wr_drop !== 1'b0) begin
      tests_failed++; $display("FAIL drop_done: done=%b drop=%b required 1 0", op_done, wr_drop);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (op_done === 1'b1) extra_done++;
    end
    tests_run++;
    if (extra_done != 0) begin
      tests_failed++; $display("FAIL drop_no_second_done: got %0d required 0", extra_done);
    end
    address_r = 7'd3; #1;
    tests_run++;
    if (data_r !== 8'h22) begin
      tests_failed++; $display("FAIL drop_mem3: got %h required 22", data_r);
    end
    address_r = 7'd9; #1;
    tests_run++;
    if (data_r !== 8'h11) begin
      tests_failed++; $display("FAIL drop_mem9: got %h required 11", data_r);
    end
  endtask

  task automatic test_same_edge();
    write_mem(7'd4, 8'h55);
    we = 1'b1; address_w = 7'd2; data_w = 8'h44;
    start_op(2'b01, 7'd2, 7'd4);
    we = 1'b0;
    tests_run++;
    if (wr_drop !== 1'b0) begin
      tests_failed++; $display("FAIL edge_no_drop: got %b required 0", wr_drop);
    end
    repeat (4) step();
    address_r = 7'd2; #1;
    tests_run++;
    if (data_r !== 8'h55) begin
      tests_failed++; $display("FAIL edge_mem2: got %h required 55", data_r);
    end
    address_r = 7'd4; #1;
    tests_run++;
    if (data_r !== 8'h44) begin
      tests_failed++; $display("FAIL edge_mem4: got %h required 44", data_r);
    end
  endtask

  task automatic test_reset_abort();
    int late_done = 0;
    write_mem(7'd3, 8'h11);
    write_mem(7'd9, 8'h22);
    start_op(2'b01, 7'd3, 7'd9);
    step();
    step();
    // In WR_B: mem[3] already rewritten, mem[9] not yet
    address_r = 7'd3; #1;
    tests_run++;
    if (data_r !== 8'h22) begin
      tests_failed++; $display("FAIL mid_op_read: got %h required 22", data_r);
    end
    reset_n = 1'b0; #1;
    tests_run++;
    if (op_ready !== 1'b1 || op_done !== 1'b0) begin
      tests_failed++; $display("FAIL abort_outputs: ready=%b done=%b required 1 0", op_ready, op_done);
    end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (op_done === 1'b1) late_done++;
      step();
    end
    tests_run++;
    if (late_done != 0) begin
      tests_failed++; $display("FAIL abort_no_done: got %0d required 0", late_done);
    end
    address_r = 7'd3; #1;
    tests_run++;
    if (data_r !== 8'h22) begin
      tests_failed++; $display("FAIL abort_mem3: got %h required 22", data_r);
    end
    address_r = 7'd9; #1;
    tests_run++;
    if (data_r !== 8'h22) begin
      tests_failed++; $display("FAIL abort_mem9: got %h required 22", data_r);
    end
  endtask

  initial begin
    test_reset();
    test_swap();
    test_copy_clear();
    test_swap_same();
    test_drop();
    test_same_edge();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
